// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit that bridges an execute-stage request to a word-wide bus.
// Checks alignment, lane-aligns store data and byte enables, and shifts and extends load data.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // Both request and bus sides use valid/ready: a transfer happens on the rising edge
    // where valid and ready (req_ready / mem_gnt) are both 1; valid and payload hold until then.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_wdsrc,
    input  logic [2:0]        req_ldsel,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    // FSM state: 0 = IDLE, 1 = REQ, 2 = WAIT, 3 = RESP
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B  = 2'd0;
    localparam logic [1:0] SZ_H  = 2'd1;
    localparam logic [1:0] SZ_W  = 2'd2;

    localparam logic [2:0] LD_RDS8  = 3'd0;
    localparam logic [2:0] LD_RDS16 = 3'd1;
    localparam logic [2:0] LD_RD32  = 3'd2;
    localparam logic [2:0] LD_RDZ8  = 3'd3;
    localparam logic [2:0] LD_RDZ16 = 3'd4;

    state_t              state_q, state_d;
    logic                accept;
    logic                illegal;
    logic [3:0]          be_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_data;

    logic                we_q;
    logic [2:0]          ldsel_q;
    logic [1:0]          off_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    assign accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        illegal = 1'b0;
        if (req_we) begin
            case (req_wdsrc)
                SZ_B:    illegal = 1'b0;
                SZ_H:    illegal = req_addr[0];
                SZ_W:    illegal = |req_addr[1:0];
                default: illegal = 1'b1;
            endcase
        end else begin
            case (req_ldsel)
                LD_RDS8, LD_RDZ8:   illegal = 1'b0;
                LD_RDS16, LD_RDZ16: illegal = req_addr[0];
                LD_RD32:            illegal = |req_addr[1:0];
                default:            illegal = 1'b1;
            endcase
        end
    end

    // Stores replicate the datum across every lane so the byte enables alone pick the target bytes.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
        if (req_we) begin
            case (req_wdsrc)
                SZ_B: begin
                    be_d    = 4'b0001 << req_addr[1:0];
                    wdata_d = {4{req_wdata[7:0]}};
                end
                SZ_H: begin
                    be_d    = 4'b0011 << req_addr[1:0];
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        shifted   = mem_rdata >> {off_q, 3'b000};
        load_data = '0;
        case (ldsel_q)
            LD_RDS8:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            LD_RDZ8:  load_data = {24'h0, shifted[7:0]};
            LD_RDS16: load_data = {{16{shifted[15]}}, shifted[15:0]};
            LD_RDZ16: load_data = {16'h0, shifted[15:0]};
            LD_RD32:  load_data = shifted;
            default:  load_data = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = illegal ? S_RESP : S_REQ;
            end
            S_REQ:  if (mem_gnt)    state_d = S_WAIT;
            S_WAIT: if (mem_rvalid) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            ldsel_q <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                ldsel_q <= req_ldsel;
                off_q   <= req_addr[1:0];
                addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                be_q    <= be_d;
                wdata_q <= wdata_d;
                err_q   <= illegal;
                rdata_q <= '0;
            end
            // Stores complete through the same rvalid path but must report zero data.
            if ((state_q == S_WAIT) && mem_rvalid) begin
                rdata_q <= we_q ? '0 : load_data;
            end
        end
    end

    assign mem_req    = (state_q == S_REQ);
    assign mem_we     = we_q && mem_req;
    assign mem_addr   = addr_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = err_q && resp_valid;
    assign resp_rdata = rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-level memory model predicts every response, and a bus
// slave with a word memory answers the DUT's bus requests with programmable delays.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_we;
    logic [1:0]  req_wdsrc;
    logic [2:0]  req_ldsel;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [1:0]  dbg_state;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wdsrc(req_wdsrc), .req_ldsel(req_ldsel), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];   // {err, rdata}
    logic [32:0] bus_q[$];   // {we, word address}
    logic [7:0]  ref_mem [64];
    logic [31:0] slave_mem [16];

    int gnt_mode = -1;       // -1 = random 0..3 cycles
    int rv_mode  = -1;
    int slv_s = 0, slv_cnt = 0, held = 0;
    int req_cycles = 0, bus_txns = 0, resp_count = 0, last_resp_cyc = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [32:0] model(input logic we, input logic [1:0] ws,
                                          input logic [2:0] ls, input logic [31:0] a,
                                          input logic [31:0] wd);
        int sz;
        bit sgn;
        int base;
        logic [31:0] v;
        sz = 0;
        sgn = 0;
        if (we) begin
            sz = (ws == 0) ? 1 : (ws == 1) ? 2 : (ws == 2) ? 4 : 0;
        end else begin
            case (ls)
                3'd0: begin sz = 1; sgn = 1; end
                3'd1: begin sz = 2; sgn = 1; end
                3'd2: sz = 4;
                3'd3: sz = 1;
                3'd4: sz = 2;
                default: sz = 0;
            endcase
        end
        if (sz == 0 || (a % sz) != 0) return {1'b1, 32'h0};
        base = int'(a[5:0]);
        if (we) begin
            for (int i = 0; i < sz; i++) ref_mem[base + i] = wd[8*i +: 8];
            return 33'h0;
        end
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return {1'b0, v};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) ref_mem[int'({a[5:2], 2'b00}) + i] = d[8*i +: 8];
        slave_mem[a[5:2]] = d;
    endtask

    // ---------------- bus slave ----------------
    initial begin
        logic [32:0] e;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                slv_s = 0;
                continue;
            end
            if (mem_req) req_cycles++;
            if (slv_s == 0 && mem_req) begin
                slv_s = 1;
                held = 0;
                slv_cnt = (gnt_mode < 0) ? int'($urandom_range(0, 3)) : gnt_mode;
                last_addr = mem_addr;
                last_be = mem_be;
                last_wdata = mem_wdata;
                last_we = mem_we;
            end
            if (slv_s == 1) begin
                if (held > 0) begin
                    chk("bus_hold_ctrl", {mem_req, mem_we, mem_be, mem_addr},
                        {1'b1, last_we, last_be, last_addr});
                    chk("bus_hold_wdata", mem_wdata, last_wdata);
                end
                held++;
                if (slv_cnt == 0) begin
                    mem_gnt = 1'b1;
                    bus_txns++;
                    if (bus_q.size() == 0) fail("bus_unexpected_req");
                    else begin
                        e = bus_q.pop_front();
                        chk("bus_we_addr", {mem_we, mem_addr}, e);
                    end
                    if (mem_we)
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) slave_mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    slv_s = 2;
                    slv_cnt = (rv_mode < 0) ? int'($urandom_range(0, 3)) : rv_mode;
                end else begin
                    slv_cnt--;
                end
            end else if (slv_s == 2) begin
                if (slv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = last_we ? $urandom : slave_mem[last_addr[5:2]];
                    slv_s = 0;
                end else begin
                    slv_cnt--;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                resp_count++;
                last_resp_cyc = cyc;
                chk("ready_low_in_resp", req_ready, 1'b0);
                if (exp_q.size() == 0) fail("resp_unexpected");
                else begin
                    e = exp_q.pop_front();
                    chk("resp_err_rdata", {resp_err, resp_rdata}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic we, input logic [1:0] ws, input logic [2:0] ls,
                         input logic [31:0] a, input logic [31:0] wd, input bit keep,
                         output int acc);
        int budget;
        logic [32:0] r;
        budget = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_wdsrc = ws;
        req_ldsel = ls;
        req_addr = a;
        req_wdata = wd;
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        acc = cyc;
        if (!req_ready) begin
            fail("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        r = model(we, ws, ls, a, wd);
        exp_q.push_back(r);
        if (!r[32]) bus_q.push_back({we, a[31:2], 2'b00});
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n0, output int rc);
        int budget;
        budget = 0;
        rc = -1;
        while (resp_count <= n0 && budget < 100) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (resp_count <= n0) fail("resp_timeout");
        else rc = last_resp_cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_err"}, resp_err, 1'b0);
        chk({tag, "_mem_req_we"}, {mem_req, mem_we}, 2'b00);
        chk({tag, "_mem_be"}, mem_be, 4'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_state"}, dbg_state, 2'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ac, ac2, rc, n0, snap_req, snap_txn, budget;
        logic        we;
        logic [1:0]  ws;
        logic [2:0]  ls;
        logic [31:0] a;
        bit          keep;

        req_valid = 1'b0;
        req_we = 1'b0;
        req_wdsrc = 2'd0;
        req_ldsel = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) set_word(32'(i * 4), $urandom);

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // LW, fastest bus
        gnt_mode = 0;
        rv_mode = 0;
        set_word(32'h100, 32'hDEAD_BEEF);
        n0 = resp_count;
        issue(1'b0, 2'd0, 3'd2, 32'h100, 32'h0, 1'b0, ac);
        wait_resp(n0, rc);
        chk("lw_latency", rc - ac, 3);
        chk("lw_bus_addr", last_addr, 32'h100);
        chk("lw_bus_be", last_be, 4'hF);

        // LB / LBU from the top byte
        set_word(32'h100, 32'h80FF_FFFF);
        n0 = resp_count;
        issue(1'b0, 2'd0, 3'd0, 32'h103, 32'h0, 1'b0, ac);
        wait_resp(n0, rc);
        chk("lb_bus_be", last_be, 4'hF);
        n0 = resp_count;
        issue(1'b0, 2'd0, 3'd3, 32'h103, 32'h0, 1'b0, ac);
        wait_resp(n0, rc);

        // SH upper half with a slow grant
        gnt_mode = 3;
        req_cycles = 0;
        n0 = resp_count;
        issue(1'b1, 2'd1, 3'd0, 32'h202, 32'h1234_ABCD, 1'b0, ac);
        wait_resp(n0, rc);
        chk("sh_req_cycles", req_cycles, 4);
        chk("sh_bus_addr", last_addr, 32'h200);
        chk("sh_bus_be", last_be, 4'b1100);
        chk("sh_bus_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_bus_we", last_we, 1'b1);
        n0 = resp_count;
        issue(1'b0, 2'd0, 3'd2, 32'h200, 32'h0, 1'b0, ac);
        wait_resp(n0, rc);

        // misaligned accesses never reach the bus
        gnt_mode = 0;
        snap_req = req_cycles;
        snap_txn = bus_txns;
        n0 = resp_count;
        issue(1'b0, 2'd0, 3'd2, 32'h101, 32'h0, 1'b0, ac);
        wait_resp(n0, rc);
        chk("lw_mis_latency", rc - ac, 1);
        n0 = resp_count;
        issue(1'b1, 2'd1, 3'd0, 32'h203, 32'h5555_AAAA, 1'b0, ac);
        wait_resp(n0, rc);
        chk("sh_mis_latency", rc - ac, 1);
        n0 = resp_count;
        issue(1'b1, 2'd3, 3'd0, 32'h200, 32'h0, 1'b0, ac);
        wait_resp(n0, rc);
        n0 = resp_count;
        issue(1'b0, 2'd0, 3'd6, 32'h200, 32'h0, 1'b0, ac);
        wait_resp(n0, rc);
        chk("illegal_no_mem_req", req_cycles, snap_req);
        chk("illegal_no_bus_txn", bus_txns, snap_txn);

        // reset while waiting for read data
        rv_mode = 6;
        n0 = resp_count;
        issue(1'b0, 2'd0, 3'd2, 32'h104, 32'h0, 1'b0, ac);
        budget = 0;
        while (slv_s != 2 && budget < 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (slv_s != 2) fail("wait_state_timeout");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        exp_q.delete();
        bus_q.delete();
        #2;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("midreset_no_resp", resp_count, n0);
        rv_mode = 0;
        gnt_mode = -1;
        n0 = resp_count;
        issue(1'b0, 2'd0, 3'd2, 32'h104, 32'h0, 1'b0, ac);
        wait_resp(n0, rc);

        // back-to-back with req_valid held high
        gnt_mode = 0;
        rv_mode = 0;
        n0 = resp_count;
        issue(1'b0, 2'd0, 3'd2, 32'h108, 32'h0, 1'b1, ac);
        issue(1'b0, 2'd0, 3'd4, 32'h10E, 32'h0, 1'b0, ac2);
        chk("b2b_accept_after_resp", ac2 - last_resp_cyc, 1);
        chk("b2b_accept_spacing", ac2 - ac, 4);
        wait_resp(n0 + 1, rc);

        // randomized traffic over a 64-byte window at two bases
        gnt_mode = -1;
        rv_mode = -1;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            ws = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ls = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 1) != 0) ? 32'h0000_1000 : 32'hA5A5_0040;
            a[5:0] = 6'($urandom_range(0, 63));
            keep = ($urandom_range(0, 1) != 0) && (i != 299);
            issue(we, ws, ls, a, $urandom, keep, ac);
        end
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_exp_q", exp_q.size(), 0);
        chk("drain_bus_q", bus_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width (only 32 supported).
REQ-002 Port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port req_valid  in  1  execute stage presents a memory request.
REQ-005 Port req_ready  out  1  unit accepts a request this cycle.
REQ-006 Port req_we  in  1  1 = store, 0 = load (decoder mem_d_we).
REQ-007 Port req_wdsrc  in  2  store size: 0 = B, 1 = H, 2 = W; 3 = illegal.
REQ-008 Port req_ldsel  in  3  load format: 0 = RDS8, 1 = RDS16, 2 = RD32, 3 = RDZ8, 4 = RDZ16; 5-7 = illegal.
REQ-009 Port req_addr  in  ADDR_W  byte address (ALU result).
REQ-010 Port req_wdata  in  DATA_W  store data (rs2, LSB-aligned).
REQ-011 Port resp_valid  out  1  one-cycle completion pulse.
REQ-012 Port resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
REQ-013 Port resp_err  out  1  valid with resp_valid; 1 = misaligned or illegal size.
REQ-014 Port mem_req  out  1  bus request.
REQ-015 Port mem_gnt  in  1  bus accepts the request.
REQ-016 Port mem_addr  out  ADDR_W  word address, bits [1:0] = 0.
REQ-017 Port mem_we  out  1  bus write.
REQ-018 Port mem_be  out  4  byte enables.
REQ-019 Port mem_wdata  out  DATA_W  lane-replicated write data.
REQ-020 Port mem_rvalid  in  1  bus completion, for both loads and stores.
REQ-021 Port mem_rdata  in  DATA_W  read word.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-023 On req_valid & req_ready, the unit SHALL register we, size/format, addr and wdata, then go to RESP with err = 1 if the access is illegal, else to REQ.
REQ-024 An access SHALL be illegal if: H/RDS16/RDZ16 with addr[0] = 1; W/RD32 with addr[1:0] != 0; or an illegal size/format code. Illegal accesses SHALL never assert mem_req.
REQ-025 In REQ, mem_req SHALL be 1 and mem_addr/we/be/wdata SHALL be held stable from registers until mem_gnt; on mem_gnt the FSM SHALL go to WAIT.
REQ-026 mem_be SHALL be: B = 4'b0001 << addr[1:0]; H = 4'b0011 << addr[1:0]; W = 4'b1111; loads = 4'b1111.
REQ-027 mem_wdata SHALL be: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-028 In WAIT, mem_rvalid SHALL move the FSM to RESP and capture read data. mem_rvalid in any other state SHALL be ignored. The bus shall assert mem_rvalid no earlier than the cycle after mem_gnt.
REQ-029 Load data SHALL be x = mem_rdata >> (8*addr[1:0]). Results: RDS8 = sign-extended x[7:0]; RDZ8 = zero-extended x[7:0]; RDS16 = sign-extended x[15:0]; RDZ16 = zero-extended x[15:0]; RD32 = x.
REQ-030 RESP SHALL last exactly one cycle with resp_valid = 1, then return to IDLE; a new request SHALL be acceptable the following cycle.
REQ-031 Minimum latency SHALL be 4 cycles from acceptance to resp_valid: accept (IDLE), REQ with gnt, WAIT with rvalid, RESP. Errors SHALL take 2 cycles: accept, RESP.
REQ-032 At most one transaction SHALL be outstanding; no pipelining.

Reset
REQ-033 rst_n low SHALL immediately force IDLE and drive req_ready = 1 and resp_valid, resp_err, mem_req, mem_we = 0. mem_be, mem_addr, mem_wdata and resp_rdata SHALL be 0.
REQ-034 Reset mid-transaction SHALL abandon it with no resp_valid. The bus slave shall share rst_n.

Verification
REQ-035 LW addr 0x100, gnt on 1st REQ cycle, rvalid next cycle with rdata 0xDEADBEEF -> mem_addr 0x100, be 4'hF, resp_valid 4 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-036 LB addr 0x103, rdata 0x80FF_FFFF -> be 4'hF, resp_rdata 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-037 SH addr 0x202, wdata 0x1234ABCD, gnt held low 3 cycles -> mem_req held 4 cycles, addr 0x200, be 4'b1100, wdata 0xABCDABCD, resp_rdata 0.
REQ-038 LW addr 0x101 and SH addr 0x203 -> no mem_req, resp_valid with err = 1 two cycles after accept.
REQ-039 rst_n low while in WAIT -> outputs at reset values, no resp_valid, next request accepted normally.
REQ-040 Back-to-back requests with req_valid held high -> req_ready low from acceptance through RESP, second request accepted the cycle after resp_valid.
